// File: rtl/icnd2110_in.sv
// icnd2110_in: decodes the ICND2110 serial stream back into PWM word writes
module icnd2110_in #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int MAX_CHIPS         = 64,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clock_in,
    input  logic                         data_in,
    input  logic [15:0]                  start_address,
    output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
    output logic [15:0]                  write_data,
    output logic                         write_strobe,
    output logic [15:0]                  config_reg,
    output logic                         config_valid,
    output logic [15:0]                  word_count,
    output logic                         frame_done,
    output logic                         frame_error,
    output logic                         busy
);
    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(MAX_CHIPS + 1);

    typedef enum logic [2:0] {IDLE, BLANK, CONFIG, GRP_A, GRP_B, ENDM} state_t;

    state_t        r_state, r_tgt, w_nx, w_tgt;
    logic [1:0]    r_ck_s, r_d_s;
    logic          r_ck_q;
    logic [7:0]    r_ones;
    logic [6:0]    r_cnt;
    logic [95:0]   r_buf;
    logic [AW-1:0] r_base, r_cbase;
    logic [CW-1:0] r_chips;
    logic          r_cact;
    logic [2:0]    r_k;
    logic [TW-1:0] r_tmo;
    logic          w_rise, w_bit, w_err, w_done, w_start, w_cfg, w_commit, w_shift;
    logic [15:0]   w_cfg_word;

    assign busy = r_state != IDLE;

    always_comb begin
        w_rise     = r_ck_s[1] & ~r_ck_q;
        w_bit      = r_d_s[1];
        w_cfg_word = {r_buf[14:0], w_bit};
        w_nx       = r_state;
        w_tgt      = r_tgt;
        w_err      = 1'b0;
        w_done     = 1'b0;
        w_start    = 1'b0;
        w_cfg      = 1'b0;
        w_commit   = 1'b0;
        w_shift    = w_rise && (r_state == CONFIG || ((r_state == GRP_A || r_state == GRP_B) && r_cnt != 7'd96));
        if (r_state != IDLE && r_tmo == TW'(TIMEOUT_CYCLES))
            w_err = 1'b1;
        else if (w_rise)
            unique case (r_state)
                IDLE:
                    if (!w_bit && r_ones >= 8'd128) begin
                        w_start = 1'b1;
                        w_nx    = BLANK;
                        w_tgt   = CONFIG;
                    end
                BLANK:
                    if (w_bit) w_err = 1'b1;
                    else if (r_cnt == 7'd15) w_nx = r_tgt;
                CONFIG:
                    if (r_cnt == 7'd15) begin
                        if (w_cfg_word[2:0] != 3'b111) w_err = 1'b1;
                        else begin
                            w_cfg = 1'b1;
                            w_nx  = BLANK;
                            w_tgt = GRP_A;
                        end
                    end
                GRP_A, GRP_B:
                    if (r_cnt == 7'd96) begin
                        if (!w_bit) begin
                            if (r_state == GRP_B && r_chips == CW'(MAX_CHIPS)) w_err = 1'b1;
                            else begin
                                w_commit = 1'b1;
                                w_nx     = BLANK;
                                w_tgt    = r_state == GRP_A ? GRP_B : GRP_A;
                            end
                        end else if (r_state == GRP_A && &r_buf) w_nx = ENDM;
                        else w_err = 1'b1;
                    end
                ENDM:
                    if (!w_bit) begin
                        if (r_ones == 8'd145) begin
                            w_done = 1'b1;
                            w_nx   = IDLE;
                        end else w_err = 1'b1;
                    end
                default: w_err = 1'b1;
            endcase
        if (w_err) w_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_tgt         <= IDLE;
            r_ck_s        <= '0;
            r_d_s         <= '0;
            r_ck_q        <= 1'b0;
            r_ones        <= '0;
            r_cnt         <= '0;
            r_buf         <= '0;
            r_base        <= '0;
            r_cbase       <= '0;
            r_chips       <= '0;
            r_cact        <= 1'b0;
            r_k           <= '0;
            r_tmo         <= '0;
            write_address <= '0;
            write_data    <= '0;
            write_strobe  <= 1'b0;
            config_reg    <= '0;
            config_valid  <= 1'b0;
            word_count    <= '0;
            frame_done    <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            r_ck_s       <= {r_ck_s[0], clock_in};
            r_d_s        <= {r_d_s[0], data_in};
            r_ck_q       <= r_ck_s[1];
            r_state      <= w_nx;
            r_tgt        <= w_tgt;
            frame_error  <= w_err;
            frame_done   <= w_done;
            config_valid <= w_cfg;
            r_tmo        <= (r_state == IDLE || w_rise) ? '0 : r_tmo + TW'(1);
            r_ones       <= w_err ? '0 : !w_rise ? r_ones :
                            (w_nx == ENDM && r_state != ENDM) ? 8'd97 :
                            ((r_state == IDLE || r_state == ENDM) && w_bit) ? r_ones + {7'd0, ~&r_ones} : '0;
            if (w_rise)
                r_cnt <= (w_nx == r_state) ? r_cnt + 7'd1 :
                         (w_nx == BLANK && r_state != CONFIG) ? 7'd1 : 7'd0;
            if (w_cfg) config_reg <= w_cfg_word;
            if (w_start) begin
                r_base     <= AW'(start_address);
                r_chips    <= '0;
                word_count <= '0;
            end
            // buffer shifts in data bits and rotates one word per commit cycle, so it stays intact
            if (w_shift) r_buf <= {r_buf[94:0], w_bit};
            else if (r_cact) r_buf <= {r_buf[79:0], r_buf[95:80]};
            if (w_commit) begin
                r_cact  <= 1'b1;
                r_k     <= '0;
                r_cbase <= r_base + AW'(r_state == GRP_A ? 5 : 11);
                if (r_state == GRP_B) begin
                    r_base  <= r_base + AW'(12);
                    r_chips <= r_chips + CW'(1);
                end
            end else if (r_cact) begin
                r_k     <= r_k + 3'd1;
                r_cact  <= r_k != 3'd5;
                r_cbase <= r_cbase - AW'(1);
            end
            write_strobe <= r_cact;
            if (r_cact) begin
                write_address <= r_cbase;
                write_data    <= r_buf[95:80];
                word_count    <= word_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_icnd2110_in.sv
// tb_icnd2110_in: directed serial frames into icnd2110_in with hand-computed expectations
module tb_icnd2110_in;
    logic        clk = 1'b0;
    logic        rst, clock_in, data_in;
    logic [15:0] start_address;
    logic [15:0] write_address, write_data, config_reg, word_count;
    logic        write_strobe, config_valid, frame_done, frame_error, busy;

    int errors = 0;
    int checks = 0;
    int m_wr = 0, m_cfg = 0, m_err = 0, m_done = 0;
    logic [15:0] q_addr[$], q_data[$];

    icnd2110_in dut (
        .clk(clk), .rst(rst), .clock_in(clock_in), .data_in(data_in),
        .start_address(start_address), .write_address(write_address),
        .write_data(write_data), .write_strobe(write_strobe),
        .config_reg(config_reg), .config_valid(config_valid),
        .word_count(word_count), .frame_done(frame_done),
        .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_strobe) begin
            m_wr++;
            q_addr.push_back(write_address);
            q_data.push_back(write_data);
        end
        if (config_valid) m_cfg++;
        if (frame_error) m_err++;
        if (frame_done) m_done++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        clock_in = 1'b0;
        data_in  = b;
        repeat (5) @(negedge clk);
        clock_in = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_n(input logic b, input int n);
        for (int i = 0; i < n; i++) send_bit(b);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_head(input logic [15:0] cfg);
        send_n(1'b1, 130);
        send_n(1'b0, 16);
        send_word(cfg);
        send_n(1'b0, 16);
    endtask

    // group words k=0..5 carry mem[base+off-k] = 0x1000+address, followed by the blank
    task automatic send_group(input logic [15:0] base, input int off);
        for (int k = 0; k < 6; k++) send_word(16'h1000 + base + 16'(off - k));
        send_n(1'b0, 16);
    endtask

    task automatic send_end();
        send_n(1'b1, 145);
        send_n(1'b0, 4);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int w0, e0, d0, c0;
        logic [15:0] a;
        rst = 1'b1;
        clock_in = 1'b0;
        data_in = 1'b0;
        start_address = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_ctl", {27'd0, write_strobe, frame_done, frame_error, busy, config_valid}, 32'd0);
        check("rst_cfg", {16'd0, config_reg}, 32'd0);
        check("rst_wc", {16'd0, word_count}, 32'd0);
        check("rst_wa", {16'd0, write_address}, 32'd0);
        rst = 1'b0;

        // loopback frame: 2 chips at 0x0100
        start_address = 16'h0100;
        w0 = m_wr; e0 = m_err; d0 = m_done; c0 = m_cfg;
        send_head(16'h0017);
        for (int c = 0; c < 2; c++) begin
            send_group(16'h0100 + 16'(12 * c), 5);
            send_group(16'h0100 + 16'(12 * c), 11);
        end
        send_end();
        check("lb_writes", m_wr - w0, 24);
        for (int j = 0; j < 24; j++) begin
            a = 16'h0100 + 16'(12 * (j / 12)) + 16'(((j % 12) < 6) ? 5 - j % 6 : 11 - j % 6);
            check("lb_addr", {16'd0, q_addr[w0 + j]}, {16'd0, a});
            check("lb_data", {16'd0, q_data[w0 + j]}, {16'd0, 16'h1000 + a});
        end
        check("lb_cfg", {16'd0, config_reg}, 32'h0017);
        check("lb_cfgv", m_cfg - c0, 1);
        check("lb_done", m_done - d0, 1);
        check("lb_err", m_err - e0, 0);
        check("lb_wc", {16'd0, word_count}, 24);
        check("lb_busy", {31'd0, busy}, 0);

        // group A all ones followed by blank commits instead of ending
        start_address = 16'h0200;
        w0 = m_wr; e0 = m_err; d0 = m_done;
        send_head(16'h0017);
        send_n(1'b1, 96);
        send_n(1'b0, 16);
        check("ff_busy", {31'd0, busy}, 1);
        send_group(16'h0200, 11);
        send_end();
        check("ff_writes", m_wr - w0, 12);
        for (int k = 0; k < 6; k++) begin
            check("ff_addr", {16'd0, q_addr[w0 + k]}, {16'd0, 16'h0205 - 16'(k)});
            check("ff_data", {16'd0, q_data[w0 + k]}, 32'hFFFF);
        end
        check("ff_done", m_done - d0, 1);
        check("ff_err", m_err - e0, 0);
        check("ff_wc", {16'd0, word_count}, 12);

        // 127 ones is not a start
        e0 = m_err; c0 = m_cfg;
        send_n(1'b1, 127);
        send_n(1'b0, 40);
        check("p127_busy", {31'd0, busy}, 0);
        check("p127_cfgv", m_cfg - c0, 0);
        check("p127_err", m_err - e0, 0);

        // a 1 at blank bit 9 after config, then a clean 1-chip frame
        start_address = 16'h0300;
        w0 = m_wr; e0 = m_err;
        send_n(1'b1, 130);
        send_n(1'b0, 16);
        send_word(16'h0017);
        send_n(1'b0, 8);
        send_bit(1'b1);
        send_n(1'b0, 7);
        check("b9_err", m_err - e0, 1);
        check("b9_writes", m_wr - w0, 0);
        check("b9_busy", {31'd0, busy}, 0);
        w0 = m_wr; e0 = m_err; d0 = m_done;
        send_head(16'h0017);
        send_group(16'h0300, 5);
        send_group(16'h0300, 11);
        send_end();
        check("cl_writes", m_wr - w0, 12);
        check("cl_addr0", {16'd0, q_addr[w0]}, 32'h0305);
        check("cl_data0", {16'd0, q_data[w0]}, 32'h1305);
        check("cl_addr11", {16'd0, q_addr[w0 + 11]}, 32'h0306);
        check("cl_data11", {16'd0, q_data[w0 + 11]}, 32'h1306);
        check("cl_done", m_done - d0, 1);
        check("cl_err", m_err - e0, 0);

        // zero-chip frames: 144-one end marker fails, 145 succeeds
        e0 = m_err; d0 = m_done;
        send_head(16'h00AF);
        send_n(1'b1, 144);
        send_n(1'b0, 4);
        repeat (20) @(negedge clk);
        check("e144_err", m_err - e0, 1);
        check("e144_done", m_done - d0, 0);
        check("e144_busy", {31'd0, busy}, 0);
        check("e144_cfg", {16'd0, config_reg}, 32'h00AF);
        e0 = m_err; d0 = m_done;
        send_head(16'h0017);
        send_end();
        check("e145_done", m_done - d0, 1);
        check("e145_err", m_err - e0, 0);
        check("e145_wc", {16'd0, word_count}, 0);

        // clock_in stalls low mid group B
        start_address = 16'h0400;
        w0 = m_wr; e0 = m_err;
        send_head(16'h0017);
        send_group(16'h0400, 5);
        send_n(1'b0, 10);
        @(negedge clk);
        clock_in = 1'b0;
        repeat (900) @(negedge clk);
        check("to_early", m_err - e0, 0);
        repeat (200) @(negedge clk);
        check("to_err", m_err - e0, 1);
        check("to_busy", {31'd0, busy}, 0);
        check("to_writes", m_wr - w0, 6);

        // reset in the middle of a commit
        start_address = 16'h0500;
        send_head(16'h0017);
        send_n(1'b1, 3);
        send_n(1'b0, 93);
        @(negedge clk);
        clock_in = 1'b0;
        data_in = 1'b0;
        repeat (5) @(negedge clk);
        clock_in = 1'b1;
        for (int i = 0; i < 20 && !write_strobe; i++) @(negedge clk);
        check("cm_strobe", {31'd0, write_strobe}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("cm_rst_ctl", {27'd0, write_strobe, frame_done, frame_error, busy, config_valid}, 0);
        check("cm_rst_wc", {16'd0, word_count}, 0);
        check("cm_rst_cfg", {16'd0, config_reg}, 0);
        check("cm_rst_wa", {16'd0, write_address}, 0);
        rst = 1'b0;
        w0 = m_wr;
        repeat (10) @(negedge clk);
        check("cm_no_resume", m_wr - w0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
